// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the RV32I core.
// A shadow pipeline of destination-register tags follows the datapath stages after ID.
// Each source operand forwards from the youngest in-flight producer of its register.
// A stall is requested while that producer is a load whose data cannot be forwarded yet.
module fwd_hazard_unit #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int FWD_STAGES         = 3,
    parameter int LOAD_READY_STAGE   = 1,
    parameter int SEL_WIDTH          = $clog2(FWD_STAGES + 1),
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                          id_rd_wr_en,
    input  logic                          id_is_load,
    input  logic                          flush,
    output logic [SEL_WIDTH-1:0]          fwd_sel_rs1,
    output logic [SEL_WIDTH-1:0]          fwd_sel_rs2,
    output logic                          stall,
    output logic [CNT_WIDTH-1:0]          stall_cycles
);

    typedef struct packed {
        logic                          valid;
        logic [REGFILE_ADDR_WIDTH-1:0] rd;
        logic                          wr_en;
        logic                          is_load;
    } entry_t;

    // Index 0 is the EX stage; higher indices are progressively older instructions.
    entry_t pipe [FWD_STAGES];

    logic hazard_rs1;
    logic hazard_rs2;
    logic issue;

    // x0 is hard-wired to zero, so a write to it is never a forwarding source.
    function automatic logic is_match(input entry_t e,
                                      input logic [REGFILE_ADDR_WIDTH-1:0] rs);
        return e.valid && e.wr_en && (e.rd != '0) && (e.rd == rs);
    endfunction

    // Scan from the oldest stage toward EX so the youngest producer is the one that sticks.
    always_comb begin
        fwd_sel_rs1 = '0;
        fwd_sel_rs2 = '0;
        hazard_rs1  = 1'b0;
        hazard_rs2  = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (id_rs1_used && is_match(pipe[k], id_rs1_addr)) begin
                fwd_sel_rs1 = SEL_WIDTH'(k + 1);
                hazard_rs1  = pipe[k].is_load && (k < LOAD_READY_STAGE);
            end
            if (id_rs2_used && is_match(pipe[k], id_rs2_addr)) begin
                fwd_sel_rs2 = SEL_WIDTH'(k + 1);
                hazard_rs2  = pipe[k].is_load && (k < LOAD_READY_STAGE);
            end
        end
    end

    // A flush kills the ID instruction, so it can neither stall nor issue.
    assign stall = id_valid && !flush && (hazard_rs1 || hazard_rs2);
    assign issue = id_valid && !stall && !flush;

    // Tag pipeline always advances; a stalled or flushed slot enters EX as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            for (int k = FWD_STAGES - 1; k >= 1; k--) begin
                pipe[k] <= pipe[k - 1];
            end
            if (issue) begin
                pipe[0] <= '{valid: 1'b1, rd: id_rd_addr, wr_en: id_rd_wr_en,
                             is_load: id_is_load};
            end else begin
                pipe[0] <= '0;
            end
        end
    end

    // Saturating stall-cycle counter for performance monitoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard testbench for fwd_hazard_unit with a narrow stall counter.
module tb_fwd_hazard_unit;

    localparam int RFAW   = 5;
    localparam int STAGES = 3;
    localparam int LRS    = 1;
    localparam int SELW   = $clog2(STAGES + 1);
    localparam int CNTW   = 2;
    localparam int CNTMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [RFAW-1:0] id_rs1_addr = '0;
    logic [RFAW-1:0] id_rs2_addr = '0;
    logic            id_rs1_used = 1'b0;
    logic            id_rs2_used = 1'b0;
    logic [RFAW-1:0] id_rd_addr = '0;
    logic            id_rd_wr_en = 1'b0;
    logic            id_is_load = 1'b0;
    logic            flush = 1'b0;
    logic [SELW-1:0] fwd_sel_rs1;
    logic [SELW-1:0] fwd_sel_rs2;
    logic            stall;
    logic [CNTW-1:0] stall_cycles;

    fwd_hazard_unit #(
        .REGFILE_ADDR_WIDTH(RFAW),
        .FWD_STAGES(STAGES),
        .LOAD_READY_STAGE(LRS),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rd_wr_en(id_rd_wr_en), .id_is_load(id_is_load),
        .flush(flush),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .stall(stall), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } model_entry_t;

    typedef struct {
        int sel1;
        int sel2;
        int stl;
        int cnt;
    } expect_t;

    model_entry_t model [STAGES];
    int           model_cnt;
    expect_t      exp_q [$];
    int           num_checks = 0;
    int           num_errors = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic modelClear();
        for (int k = 0; k < STAGES; k++) model[k] = '{0, 0, 0, 0};
        model_cnt = 0;
    endtask

    // Reference lookup: walk from EX outward and stop at the first live writer.
    function automatic void modelLookup(input bit [4:0] rs, input bit used,
                                        output int sel, output bit hz);
        int k;
        sel = 0;
        hz  = 0;
        if (!used || rs == 0) return;
        k = 0;
        while (k < STAGES) begin
            if (model[k].valid && model[k].wr && model[k].rd == rs) begin
                sel = k + 1;
                hz  = model[k].ld && (k < LRS);
                return;
            end
            k++;
        end
    endfunction

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic compareOutputs(input string tag);
        expect_t e;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        checkOutput({tag, "_sel1"}, int'(fwd_sel_rs1), e.sel1);
        checkOutput({tag, "_sel2"}, int'(fwd_sel_rs2), e.sel2);
        checkOutput({tag, "_stall"}, int'(stall), e.stl);
        checkOutput({tag, "_cnt"}, int'(stall_cycles), e.cnt);
    endtask

    // Drive one ID slot, predict outputs, check them, then advance the model one clock.
    task automatic applyStimulus(input string tag, input bit v,
                                 input bit [4:0] rs1, input bit u1,
                                 input bit [4:0] rs2, input bit u2,
                                 input bit [4:0] rd, input bit wr, input bit ld,
                                 input bit fl);
        expect_t e;
        bit hz1, hz2, st;
        @(negedge clk);
        id_valid = v; id_rs1_addr = rs1; id_rs1_used = u1;
        id_rs2_addr = rs2; id_rs2_used = u2;
        id_rd_addr = rd; id_rd_wr_en = wr; id_is_load = ld; flush = fl;
        modelLookup(rs1, u1, e.sel1, hz1);
        modelLookup(rs2, u2, e.sel2, hz2);
        st    = v && !fl && (hz1 || hz2);
        e.stl = int'(st);
        e.cnt = model_cnt;
        exp_q.push_back(e);
        #1;
        compareOutputs(tag);
        @(posedge clk);
        for (int k = STAGES - 1; k >= 1; k--) model[k] = model[k - 1];
        if (v && !st && !fl) model[0] = '{1, rd, wr, ld};
        else                 model[0] = '{0, 0, 0, 0};
        if (st && model_cnt < CNTMAX) model_cnt++;
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        modelClear();
        // Outputs must be quiet while reset is held.
        @(negedge clk);
        exp_q.push_back('{0, 0, 0, 0});
        #1 compareOutputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // EX-stage forward on rs1.
        applyStimulus("add_x5", 1, 0, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus("use_x5_rs1", 1, 5, 1, 0, 0, 0, 0, 0, 0);
        idle("drain0"); idle("drain1");

        // MEM-stage forward on rs2 across a bubble.
        applyStimulus("add_x5b", 1, 0, 0, 0, 0, 5, 1, 0, 0);
        idle("nop");
        applyStimulus("use_x5_rs2", 1, 0, 0, 5, 1, 0, 0, 0, 0);
        idle("drain2"); idle("drain3");

        // Same rd in stages 0 and 2: youngest wins.
        applyStimulus("x5_old", 1, 0, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus("x6_mid", 1, 0, 0, 0, 0, 6, 1, 0, 0);
        applyStimulus("x5_new", 1, 0, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus("use_both", 1, 5, 1, 6, 1, 0, 0, 0, 0);
        idle("drain4"); idle("drain5");

        // Load-use: one stall, counter 0->1, then forward from MEM.
        applyStimulus("lw_x7", 1, 0, 0, 0, 0, 7, 1, 1, 0);
        applyStimulus("use_x7_stall", 1, 7, 1, 7, 1, 0, 0, 0, 0);
        applyStimulus("use_x7_fwd", 1, 7, 1, 7, 1, 0, 0, 0, 0);
        idle("drain6"); idle("drain7");

        // x0 never forwards; unused operand never forwards.
        applyStimulus("wr_x0", 1, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("read_x0", 1, 0, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus("add_x9", 1, 0, 0, 0, 0, 9, 1, 0, 0);
        applyStimulus("x9_unused", 1, 9, 0, 9, 0, 0, 0, 0, 0);
        idle("drain8"); idle("drain9");

        // ALU writer younger than a load of the same register: no stall.
        applyStimulus("lw_x8", 1, 0, 0, 0, 0, 8, 1, 1, 0);
        applyStimulus("add_x8", 1, 0, 0, 0, 0, 8, 1, 0, 0);
        applyStimulus("use_x8", 1, 8, 1, 0, 0, 0, 0, 0, 0);
        idle("drain10"); idle("drain11");

        // Flush overrides a load-use hazard and inserts a bubble.
        applyStimulus("lw_x7b", 1, 0, 0, 0, 0, 7, 1, 1, 0);
        applyStimulus("flush_use", 1, 7, 1, 0, 0, 3, 1, 0, 1);
        applyStimulus("after_flush", 1, 7, 1, 3, 1, 0, 0, 0, 0);
        idle("drain12"); idle("drain13");

        // Repeated load-use pairs drive the narrow counter into saturation.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("sat_lw", 1, 0, 0, 0, 0, 10, 1, 1, 0);
            applyStimulus("sat_use", 1, 0, 0, 10, 1, 0, 0, 0, 0);
            applyStimulus("sat_go", 1, 0, 0, 10, 1, 0, 0, 0, 0);
        end
        #1 checkOutput("cnt_saturated", int'(stall_cycles), CNTMAX);

        // Reset while a stall is being requested clears everything at once.
        applyStimulus("rst_lw", 1, 0, 0, 0, 0, 11, 1, 1, 0);
        @(negedge clk);
        id_valid = 1; id_rs1_addr = 11; id_rs1_used = 1;
        id_rs2_addr = 0; id_rs2_used = 0; id_rd_addr = 0;
        id_rd_wr_en = 0; id_is_load = 0; flush = 0;
        #1 checkOutput("pre_rst_stall", int'(stall), 1);
        rst = 1'b1;
        modelClear();
        exp_q.push_back('{0, 0, 0, 0});
        #1 compareOutputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("post_rst", 1, 11, 1, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
